// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode constants, transmitter state type and parity helper
// shared by the UART transmit slice.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic logic parity_of(input logic [8:0] d, input int mode);
        return (mode == PARITY_ODD) ? ~(^d) : ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous word buffer with count-based full/empty,
// sitting between the tx handshake and the frame FSM.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (start, data LSB first, parity,
// stop). Define UART_TX_FIFO_EN to place a FIFO_DEPTH-word buffer ahead of the FSM.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_pm
        $error("PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fd
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        clk_q, clk_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 done_q, done_d;
    logic                 load;
    logic [DATA_BITS-1:0] load_data;
    logic                 tick;

`ifdef UART_TX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_valid && tx_ready),
        .wr_data (tx_data),
        .rd_en   (load),
        .rd_data (load_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tx_ready = !fifo_full && !rst;
    assign load     = (state_q == IDLE) && !fifo_empty;
`else
    assign tx_ready  = (state_q == IDLE) && !rst;
    assign load      = tx_valid && tx_ready;
    assign load_data = tx_data;
`endif

    assign tick = (clk_q == CLK_LAST);
    assign busy = (state_q != IDLE);
    assign done = done_q;

    always_comb begin
        state_d = state_q;
        clk_d   = clk_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    clk_d   = '0;
                    idx_d   = '0;
                    sh_d    = load_data;
                    par_d   = parity_of(9'(load_data), PARITY_MODE);
                end
            end
            START: begin
                clk_d = clk_q + 1'b1;
                if (tick) begin
                    state_d = DATA;
                    clk_d   = '0;
                end
            end
            DATA: begin
                clk_d = clk_q + 1'b1;
                if (tick) begin
                    clk_d = '0;
                    sh_d  = sh_q >> 1;
                    idx_d = idx_q + 4'd1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                clk_d = clk_q + 1'b1;
                if (tick) begin
                    state_d = STOP;
                    clk_d   = '0;
                end
            end
            STOP: begin
                clk_d = clk_q + 1'b1;
                if (tick) begin
                    clk_d = '0;
                    idx_d = idx_q + 4'd1;
                    // done lands on the first IDLE cycle, where a reload may also occur
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        unique case (state_q)
            START:   txd = 1'b0;
            DATA:    txd = sh_q[0];
            PARITY:  txd = par_q;
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            clk_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: three transmitter configurations driven from one random
// stream and compared cycle by cycle with a queue-based line model.
module tb_uart_tx_cfg;

    localparam int CPB = 4;
    localparam int DBW [3] = '{8, 7, 8};
    localparam int PM  [3] = '{1, 0, 2};
    localparam int SB  [3] = '{1, 2, 1};
    localparam int BUSY_EXP [3] = '{44, 40, 44};
`ifdef UART_TX_FIFO_EN
    localparam int LAT    = 1;
    localparam int FIFO_D = 4;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [8:0] data_bus = '0;
    logic [2:0] tx_ready_v;
    logic [2:0] txd_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;

    int  n_chk = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;
    bit  fq [3][$];
    int  wq [3][$];
    bit  exp_done [3];

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(data_bus[7:0]),
        .tx_ready(tx_ready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]),
        .done(done_v[0]));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(data_bus[6:0]),
        .tx_ready(tx_ready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]),
        .done(done_v[1]));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(data_bus[7:0]),
        .tx_ready(tx_ready_v[2]), .txd(txd_v[2]), .busy(busy_v[2]),
        .done(done_v[2]));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_bit(input int i, input bit b);
        repeat (CPB) fq[i].push_back(b);
    endtask

    // expand one word into the per-cycle line levels of its frame
    task automatic build(input int i, input int w);
        int ones = 0;
        push_bit(i, 1'b0);
        for (int b = 0; b < DBW[i]; b++) begin
            push_bit(i, bit'((w >> b) & 1));
            ones += (w >> b) & 1;
        end
        if (PM[i] == 1) push_bit(i, bit'(ones % 2));
        if (PM[i] == 2) push_bit(i, bit'(1 - ones % 2));
        for (int s = 0; s < SB[i]; s++) push_bit(i, 1'b1);
    endtask

    always @(posedge clk) begin : model
`ifdef UART_TX_FIFO_EN
        bit acc;
`endif
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                fq[i].delete();
                wq[i].delete();
                exp_done[i] = 1'b0;
            end else begin
                exp_done[i] = 1'b0;
`ifdef UART_TX_FIFO_EN
                acc = tx_valid && (wq[i].size() < FIFO_D);
`endif
                if (fq[i].size() != 0) begin
                    void'(fq[i].pop_front());
                    if (fq[i].size() == 0) exp_done[i] = 1'b1;
                end
`ifdef UART_TX_FIFO_EN
                else if (wq[i].size() != 0) build(i, wq[i].pop_front());
                if (acc) wq[i].push_back(int'(data_bus));
`else
                else if (tx_valid) build(i, int'(data_bus));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                bit e_txd;
                bit e_rdy;
                e_txd = (fq[i].size() != 0) ? fq[i][0] : 1'b1;
`ifdef UART_TX_FIFO_EN
                e_rdy = !rst && (wq[i].size() < FIFO_D);
`else
                e_rdy = !rst && (fq[i].size() == 0);
`endif
                chk($sformatf("txd%0d", i), 32'(txd_v[i]), 32'(e_txd));
                chk($sformatf("busy%0d", i), 32'(busy_v[i]),
                    32'(fq[i].size() != 0));
                chk($sformatf("done%0d", i), 32'(done_v[i]), 32'(exp_done[i]));
                chk($sformatf("ready%0d", i), 32'(tx_ready_v[i]), 32'(e_rdy));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((fq[0].size() + fq[1].size() + fq[2].size() + wq[0].size()
                + wq[1].size() + wq[2].size()) != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(n < 1000), 32'd1);
    endtask

    // one word, then frame length, done latency and parity bit level
    task automatic measure(input logic [8:0] d, input bit pe);
        int bc [3];
        int dc [3];
        logic pb [3];
        for (int i = 0; i < 3; i++) begin
            bc[i] = 0;
            dc[i] = 0;
            pb[i] = 1'bx;
        end
        wait_idle();
        @(posedge clk);
        #2 tx_valid = 1'b1;
        data_bus = d;
        @(posedge clk);
        #2 tx_valid = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i]) bc[i]++;
                if (done_v[i] && dc[i] == 0) dc[i] = c;
                if (c == 38 + LAT) pb[i] = txd_v[i];
            end
            if (dc[0] != 0 && dc[1] != 0 && dc[2] != 0) break;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy_len%0d", i), 32'(bc[i]), 32'(BUSY_EXP[i]));
            chk($sformatf("done_at%0d", i), 32'(dc[i]),
                32'(BUSY_EXP[i] + 1 + LAT));
        end
        chk("par_even", 32'(pb[0]), 32'(pe));
        chk("par_odd", 32'(pb[2]), 32'(!pe));
    endtask

    initial begin
        @(posedge clk);
        #2 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_txd", 32'(txd_v), 32'h7);
        chk("rst_busy", 32'(busy_v), 32'h0);
        chk("rst_done", 32'(done_v), 32'h0);
        chk("rst_ready", 32'(tx_ready_v), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        measure(9'h0A5, 1'b0);
        measure(9'h007, 1'b1);
        measure(9'h041, 1'b0);

        wait_idle();
        @(posedge clk);
        #2 tx_valid = 1'b1;
        data_bus = 9'h0A5;
        @(posedge clk);
        #2 tx_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_txd", 32'(txd_v), 32'h7);
        chk("abort_busy", 32'(busy_v), 32'h0);
        #1 rst = 1'b0;
        measure(9'h05A, 1'b0);

        @(posedge clk);
        #2 tx_valid = 1'b1;
        repeat (300) begin
            @(posedge clk);
            #2 data_bus = 9'($urandom);
        end
        tx_valid = 1'b0;
        wait_idle();

        repeat (3000) begin
            @(posedge clk);
            #2 tx_valid = ($urandom_range(0, 2) == 0);
            data_bus = 9'($urandom);
            rst = ($urandom_range(0, 399) == 0);
        end
        @(posedge clk);
        #2 tx_valid = 1'b0;
        rst = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, clk cycles per serial bit (>=2).
REQ-002 SHALL have parameter DATA_BITS, default 8, payload width (5..9).
REQ-003 SHALL have parameter PARITY_MODE, default 1, 0=none 1=even 2=odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, entries when FIFO compiled in (power of two, >=2).
REQ-006 SHALL have one clock; reset is synchronous and active-high; port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port tx_valid  input  1  word offered.
REQ-009 SHALL have port tx_data  input  DATA_BITS  word to send, sampled on accept.
REQ-010 SHALL have port tx_ready  output  1  word accepted when tx_valid&&tx_ready.
REQ-011 SHALL have port txd  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  high while a frame is on the line.
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 Frame SHALL be start(0), DATA_BITS LSB first, parity bit if PARITY_MODE!=0, STOP_BITS stop(1); each bit held exactly CLKS_PER_BIT cycles.
REQ-015 Parity SHALL be XOR of data bits (even) or its inverse (odd).
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY_MODE=0.
REQ-017 IDLE->START on load; START->DATA, DATA->PARITY/STOP after last data bit, PARITY->STOP, STOP->IDLE after last stop bit; transitions only on bit-counter terminal count.
REQ-018 txd SHALL go low the cycle after load; busy high from that cycle through last stop cycle.
REQ-019 done SHALL pulse on the first IDLE cycle after the frame; a new load in that same cycle is permitted.
REQ-020 Without FIFO: tx_ready = (state==IDLE); load = tx_valid&&tx_ready; tx_data is don't-care outside accept.
REQ-021 Min inter-frame gap SHALL be exactly one idle-high clk cycle.
REQ-022 Invalid parameter values SHALL fail elaboration.

Reset
REQ-023 During rst: txd=1, busy=0, done=0, state=IDLE, counters=0; tx_ready=0 while rst high.
REQ-024 rst mid-frame SHALL abort: txd=1 on next cycle, no done pulse, FIFO contents discarded.

Configuration
REQ-025 Macro UART_TX_FIFO_EN SHALL compile in a FIFO_DEPTH-entry buffer between handshake and FSM.
REQ-026 With macro: tx_ready = !full; write on tx_valid&&tx_ready; FSM pops when IDLE and !empty, pop loads FSM; write data visible to pop one cycle after write; simultaneous push and pop SHALL be allowed when not full; order preserved.
REQ-027 Without macro: behaviour per REQ-020, FIFO_DEPTH ignored, no FIFO storage synthesised.

Structure
REQ-028 Shared package uart_pkg SHALL hold PARITY_NONE/EVEN/ODD constants and FSM state encoding typedef.
REQ-029 FIFO SHALL be sub-module uart_tx_fifo (sync, count-based full/empty), instantiated only under UART_TX_FIFO_EN.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-030 DATA_BITS=8, even, send 0xA5 -> txd 0,1,0,1,0,0,1,0,1, parity 0, stop 1; 44 busy cycles; done at cycle 45 after accept.
REQ-031 Send 0x07 even -> parity bit 1; odd -> parity bit 0.
REQ-032 DATA_BITS=7, none, STOP_BITS=2, send 0x41 -> 10 bits, 40 busy cycles, txd high over final 8.
REQ-033 rst asserted 10 cycles into 0xA5 frame -> txd=1, busy=0 next cycle, no done; next word sends cleanly.
REQ-034 UART_TX_FIFO_EN, depth 4: tx_valid held with 0x01..0x05 on consecutive cycles -> all 5 accepted, tx_ready low after 5th, five frames in order, one idle cycle between each.
REQ-035 Without macro, tx_valid held high continuously -> tx_ready only in IDLE; back-to-back frames with one-cycle gap, done coincident with each accept.
